// File: rtl/alu_writeback_unit.sv
// alu_writeback_unit: consumer end of the ALU result/flag interface.
// Holds the NZCV flag register, evaluates the condition field against the
// stored flags, and writes passing results to the register file.
// Optional feature macro: ALU_MUL_HI_WB_EN. When it is defined, a MUL product
// is written as two DATA_W-bit writes on consecutive cycles (low half to rd,
// then high half to rd_hi). When it is undefined, only the low half is
// written and the unit never stalls.
module alu_writeback_unit #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   alu_result,
    input  logic [3:0]            alu_flags,
    input  logic [2:0]            alu_sel,
    input  logic [3:0]            cond,
    input  logic                  set_flags,
    input  logic [3:0]            rd,
    input  logic [3:0]            rd_hi,
    output logic                  wr_en,
    output logic [3:0]            wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [3:0]            flags,
    output logic                  cond_pass
);

    localparam logic [2:0] SEL_MUL = 3'b100;

    // Condition code evaluation against an {N,Z,C,V} flag vector.
    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic res;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'b0000: res = z;
            4'b0001: res = !z;
            4'b0010: res = cy;
            4'b0011: res = !cy;
            4'b0100: res = n;
            4'b0101: res = !n;
            4'b0110: res = v;
            4'b0111: res = !v;
            4'b1000: res = cy && !z;
            4'b1001: res = !cy || z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = !z && (n == v);
            4'b1101: res = z || (n != v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Only the six defined ALU operations may write back.
    function automatic logic sel_valid(input logic [2:0] s);
        return (s != 3'b110) && (s != 3'b111);
    endfunction

    logic accept_p0;
    logic issue_p0;

    assign accept_p0 = in_valid && in_ready;
    assign issue_p0  = accept_p0 && sel_valid(alu_sel) && cond_check(cond, flags);

`ifdef ALU_MUL_HI_WB_EN
    typedef enum logic {
        IDLE  = 1'b0,
        WR_HI = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [DATA_W-1:0]    hi_data_p1;
    logic [3:0]           hi_addr_p1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a passing MUL holds off upstream for one extra cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (issue_p0 && (alu_sel == SEL_MUL)) begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == IDLE);

    // High-half latch; contents are only consumed in WR_HI, so no reset.
    always_ff @(posedge clk) begin
        if (issue_p0 && (alu_sel == SEL_MUL)) begin
            hi_data_p1 <= alu_result[2*DATA_W-1:DATA_W];
            hi_addr_p1 <= rd_hi;
        end
    end

    // Register-file write port, condition pulse and flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            flags     <= '0;
            cond_pass <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            cond_pass <= 1'b0;
            if (state_q == WR_HI) begin
                wr_en   <= 1'b1;
                wr_addr <= hi_addr_p1;
                wr_data <= hi_data_p1;
            end else if (issue_p0) begin
                wr_en     <= 1'b1;
                wr_addr   <= rd;
                wr_data   <= alu_result[DATA_W-1:0];
                cond_pass <= 1'b1;
                if (set_flags) begin
                    flags <= alu_flags;
                end
            end
        end
    end
`else
    logic unused_hi;

    // Without the high-half path the unit accepts every cycle.
    assign in_ready  = 1'b1;
    assign unused_hi = ^{rd_hi, alu_result[2*DATA_W-1:DATA_W]};

    // Register-file write port, condition pulse and flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            flags     <= '0;
            cond_pass <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            cond_pass <= 1'b0;
            if (issue_p0) begin
                wr_en     <= 1'b1;
                wr_addr   <= rd;
                wr_data   <= alu_result[DATA_W-1:0];
                cond_pass <= 1'b1;
                if (set_flags) begin
                    flags <= alu_flags;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Directed testbench for alu_writeback_unit (either ALU_MUL_HI_WB_EN setting).
module tb_alu_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic [2:0]  alu_sel;
    logic [3:0]  cond;
    logic        set_flags;
    logic [3:0]  rd;
    logic [3:0]  rd_hi;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  flags;
    logic        cond_pass;

    int n_checks = 0;
    int n_fail   = 0;

    alu_writeback_unit #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .alu_sel    (alu_sel),
        .cond       (cond),
        .set_flags  (set_flags),
        .rd         (rd),
        .rd_hi      (rd_hi),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .flags      (flags),
        .cond_pass  (cond_pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the full write-port / flag state.
    task automatic chk_out(input string tag, input logic we, input logic [3:0] wa,
                           input logic [15:0] wd, input logic [3:0] fl, input logic cp,
                           input logic rdy);
        chk({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, we});
        if (we) begin
            chk({tag, ".wr_addr"}, {28'd0, wr_addr}, {28'd0, wa});
            chk({tag, ".wr_data"}, {16'd0, wr_data}, {16'd0, wd});
        end
        chk({tag, ".flags"}, {28'd0, flags}, {28'd0, fl});
        chk({tag, ".cond_pass"}, {31'd0, cond_pass}, {31'd0, cp});
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    endtask

    // Present one instruction with in_valid high.
    task automatic drive(input logic [2:0] s, input logic [3:0] c, input logic sf,
                         input logic [31:0] res, input logic [3:0] af,
                         input logic [3:0] d, input logic [3:0] dh);
        in_valid   = 1'b1;
        alu_sel    = s;
        cond       = c;
        set_flags  = sf;
        alu_result = res;
        alu_flags  = af;
        rd         = d;
        rd_hi      = dh;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        alu_result = '0; alu_flags = '0; alu_sel = '0; cond = '0;
        set_flags = 1'b0; rd = '0; rd_hi = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("reset.wr_data", {16'd0, wr_data}, 32'd0);
        chk_out("reset", 1'b0, 4'd0, 16'd0, 4'b0000, 1'b0, 1'b1);
        rst = 1'b0;

        // ADD, AL, set flags to Z
        drive(3'b000, 4'b1110, 1'b1, 32'h0000_0000, 4'b0100, 4'd3, 4'd0); step();
        chk_out("add_al", 1'b1, 4'd3, 16'h0000, 4'b0100, 1'b1, 1'b1);
        // SUB, NE with Z=1 fails
        drive(3'b001, 4'b0001, 1'b1, 32'h0000_0055, 4'b0000, 4'd5, 4'd0); step();
        chk_out("sub_ne", 1'b0, 4'd0, 16'h0, 4'b0100, 1'b0, 1'b1);
        // SUB, EQ passes, flags cleared
        drive(3'b001, 4'b0000, 1'b1, 32'h0000_0055, 4'b0000, 4'd5, 4'd0); step();
        chk_out("sub_eq", 1'b1, 4'd5, 16'h0055, 4'b0000, 1'b1, 1'b1);
        // Load N=1,V=1
        drive(3'b000, 4'b1110, 1'b1, 32'h0000_0077, 4'b1001, 4'd6, 4'd0); step();
        chk_out("set_1001", 1'b1, 4'd6, 16'h0077, 4'b1001, 1'b1, 1'b1);
        drive(3'b011, 4'b1010, 1'b0, 32'h0000_0011, 4'b0000, 4'd7, 4'd0); step();
        chk_out("ge_pass", 1'b1, 4'd7, 16'h0011, 4'b1001, 1'b1, 1'b1);
        drive(3'b010, 4'b1011, 1'b0, 32'h0000_0022, 4'b0000, 4'd8, 4'd0); step();
        chk_out("lt_fail", 1'b0, 4'd0, 16'h0, 4'b1001, 1'b0, 1'b1);
        // Load N=1,V=0
        drive(3'b101, 4'b1110, 1'b1, 32'h0000_0004, 4'b1000, 4'd4, 4'd0); step();
        chk_out("set_1000", 1'b1, 4'd4, 16'h0004, 4'b1000, 1'b1, 1'b1);
        drive(3'b000, 4'b1100, 1'b0, 32'h0000_000A, 4'b0000, 4'd10, 4'd0); step();
        chk_out("gt_fail", 1'b0, 4'd0, 16'h0, 4'b1000, 1'b0, 1'b1);
        drive(3'b000, 4'b1101, 1'b0, 32'h0000_000B, 4'b0000, 4'd11, 4'd0); step();
        chk_out("le_pass", 1'b1, 4'd11, 16'h000B, 4'b1000, 1'b1, 1'b1);
        // Invalid operation never writes or updates flags
        drive(3'b111, 4'b1110, 1'b1, 32'h0000_00CC, 4'b0110, 4'd12, 4'd0); step();
        chk_out("bad_sel", 1'b0, 4'd0, 16'h0, 4'b1000, 1'b0, 1'b1);
        drive(3'b000, 4'b1111, 1'b1, 32'h0000_00DD, 4'b0110, 4'd13, 4'd0); step();
        chk_out("nv_fail", 1'b0, 4'd0, 16'h0, 4'b1000, 1'b0, 1'b1);

        // MUL followed by an ADD presented immediately after the accept edge
        drive(3'b100, 4'b1110, 1'b0, 32'h1234_ABCD, 4'b0000, 4'd1, 4'd2); step();
`ifdef ALU_MUL_HI_WB_EN
        chk_out("mul_lo", 1'b1, 4'd1, 16'hABCD, 4'b1000, 1'b1, 1'b0);
        drive(3'b000, 4'b1110, 1'b0, 32'h0000_00AA, 4'b0000, 4'd9, 4'd0);
        @(posedge clk); #1;
        chk_out("mul_hi", 1'b1, 4'd2, 16'h1234, 4'b1000, 1'b0, 1'b1);
        step();
        chk_out("after_mul", 1'b1, 4'd9, 16'h00AA, 4'b1000, 1'b1, 1'b1);
`else
        chk_out("mul_lo", 1'b1, 4'd1, 16'hABCD, 4'b1000, 1'b1, 1'b1);
        drive(3'b000, 4'b1110, 1'b0, 32'h0000_00AA, 4'b0000, 4'd9, 4'd0); step();
        chk_out("after_mul", 1'b1, 4'd9, 16'h00AA, 4'b1000, 1'b1, 1'b1);
`endif
        step();
        chk_out("idle", 1'b0, 4'd0, 16'h0, 4'b1000, 1'b0, 1'b1);

        // Asynchronous reset right after a MUL accept drops the high write
        drive(3'b100, 4'b1110, 1'b0, 32'h5678_0F0F, 4'b0000, 4'd14, 4'd15); step();
        chk_out("mul2_lo", 1'b1, 4'd14, 16'h0F0F, 4'b1000, 1'b1,
`ifdef ALU_MUL_HI_WB_EN
                1'b0
`else
                1'b1
`endif
                );
        #1 rst = 1'b1;
        #1;
        chk("rst_mid.wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_mid.wr_data", {16'd0, wr_data}, 32'd0);
        chk_out("rst_mid", 1'b0, 4'd0, 16'h0, 4'b0000, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_out("rst_hi_dropped", 1'b0, 4'd0, 16'h0, 4'b0000, 1'b0, 1'b1);
        // Flags are zero after reset, so EQ fails and NE passes
        drive(3'b000, 4'b0000, 1'b0, 32'h0000_0001, 4'b0000, 4'd3, 4'd0); step();
        chk_out("post_rst_eq", 1'b0, 4'd0, 16'h0, 4'b0000, 1'b0, 1'b1);
        drive(3'b000, 4'b0001, 1'b0, 32'h0000_0002, 4'b0000, 4'd3, 4'd0); step();
        chk_out("post_rst_ne", 1'b1, 4'd3, 16'h0002, 4'b0000, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
